// File: rtl/decoder_seq_if.sv
// -----------------------------------------------------------------------------
// decoder_seq_if
//
// Bundles the request handshake and the decoded-output signals of decoder_seq.
//
// Parameter
//   SEL_W     select width; the output width OUT_W = 2**SEL_W is derived here.
//
// Signals
//   in_valid    direct-mode request valid            (master -> slave)
//   in_ready    block can accept a request or start  (slave  -> master)
//   sel         code to decode                       (master -> slave)
//   en          decode enable                        (master -> slave)
//   mode        0 = direct, 1 = sweep                (master -> slave)
//   start       sweep start pulse                    (master -> slave)
//   dout        registered one-hot (or all-zero)     (slave  -> master)
//   dout_valid  one-cycle strobe for a new code      (slave  -> master)
//   busy        high while sweeping or completing    (slave  -> master)
//   done        one-cycle sweep-complete pulse       (slave  -> master)
//
// Modports
//   master  the requester side (drives in_valid/sel/en/mode/start)
//   slave   the decoder side   (drives in_ready/dout/dout_valid/busy/done)
// -----------------------------------------------------------------------------
interface decoder_seq_if #(
  parameter int SEL_W = 3
);
  localparam int OUT_W = 2**SEL_W;

  logic             in_valid;
  logic             in_ready;
  logic [SEL_W-1:0] sel;
  logic             en;
  logic             mode;
  logic             start;
  logic [OUT_W-1:0] dout;
  logic             dout_valid;
  logic             busy;
  logic             done;

  modport master (
    output in_valid,
    output sel,
    output en,
    output mode,
    output start,
    input  in_ready,
    input  dout,
    input  dout_valid,
    input  busy,
    input  done
  );

  modport slave (
    input  in_valid,
    input  sel,
    input  en,
    input  mode,
    input  start,
    output in_ready,
    output dout,
    output dout_valid,
    output busy,
    output done
  );
endinterface

// File: rtl/decoder_seq.sv
// -----------------------------------------------------------------------------
// decoder_seq
//
// Registered SEL_W-to-2**SEL_W one-hot decoder with a valid/ready request
// handshake, a decode enable and an autonomous sweep mode that steps the
// one-hot output through every code (select/strobe generator and self-test
// pattern source).
//
// Parameters
//   SEL_W     select width (output width OUT_W = 2**SEL_W, not overridable)
//   STEP_CYC  dwell cycles per code while sweeping, legal range 1..255
//
// Ports
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    decoder_seq_if.slave: in_valid/in_ready/sel/en/mode/start in,
//          dout/dout_valid/busy/done out
//
// Optional build macro
//   DEC_ACTIVE_LOW_EN  when defined every dout bit is inverted (74x138 style):
//                      reset and "zero" outputs read all ones, the selected
//                      bit reads 0. dout_valid, busy and done are unaffected.
//
// Behaviour summary
//   IDLE : in_ready=1. A direct accept (in_valid & ~mode) loads dout with
//          1<<sel (or 0 when en=0) one cycle later with a one-cycle
//          dout_valid. mode & start enters SWEEP and takes priority.
//   SWEEP: dout = 1<<cnt, each code held STEP_CYC cycles, dout_valid on the
//          first cycle of every code, no wrap-around.
//   DONE : one cycle with done=1, busy=1, dout=0, then IDLE.
// -----------------------------------------------------------------------------
module decoder_seq #(
  parameter int SEL_W    = 3,
  parameter int STEP_CYC = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  decoder_seq_if.slave  bus
);

  localparam int OUT_W = 2**SEL_W;

  // Dwell counter is 8 bits wide; an out-of-range STEP_CYC of 0 is treated
  // as 1 so the counter can never wrap through 255 unintentionally.
  localparam int          STEP_EFF   = (STEP_CYC < 1) ? 1 : STEP_CYC;
  localparam logic [7:0]  DWELL_LAST = 8'(STEP_EFF - 1);
  localparam logic [SEL_W-1:0] CNT_LAST = {SEL_W{1'b1}};

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SWEEP = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  // ---------------------------------------------------------------------------
  // Helpers
  // ---------------------------------------------------------------------------
  // Exactly one bit set for any code; a single indexed write cannot produce
  // a multi-hot result.
  function automatic logic [OUT_W-1:0] onehot(input logic [SEL_W-1:0] code);
    logic [OUT_W-1:0] r;
    r       = '0;
    r[code] = 1'b1;
    return r;
  endfunction

  // Maps the internal active-high code to the pin polarity.
  function automatic logic [OUT_W-1:0] pin_level(input logic [OUT_W-1:0] v);
`ifdef DEC_ACTIVE_LOW_EN
    return ~v;
`else
    return v;
`endif
  endfunction

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_t           state_q, state_d;
  logic             in_ready_q;
  logic [SEL_W-1:0] cnt_q, cnt_d;
  logic [7:0]       dwell_q, dwell_d;
  logic [OUT_W-1:0] dout_p1, dout_d;
  logic             vld_p1, vld_d;

  logic             start_acc;
  logic             direct_acc;
  logic             last_dwell;
  logic             last_code;

  // ---------------------------------------------------------------------------
  // Stage p0: next-state and next-output decision
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    dwell_d    = dwell_q;
    dout_d     = dout_p1;
    vld_d      = 1'b0;
    start_acc  = 1'b0;
    direct_acc = 1'b0;
    last_dwell = (dwell_q == DWELL_LAST);
    last_code  = (cnt_q == CNT_LAST);

    case (state_q)
      ST_IDLE: begin
        // in_ready_q gates acceptance so nothing is taken on the first edge
        // after reset release. Start wins over a simultaneous in_valid.
        if (in_ready_q) begin
          if (bus.mode && bus.start) begin
            start_acc = 1'b1;
          end else if (!bus.mode && bus.in_valid) begin
            direct_acc = 1'b1;
          end
        end

        if (start_acc) begin
          state_d = ST_SWEEP;
          cnt_d   = '0;
          dwell_d = '0;
          dout_d  = onehot('0);
          vld_d   = 1'b1;
        end else if (direct_acc) begin
          dout_d  = bus.en ? onehot(bus.sel) : '0;
          vld_d   = 1'b1;
        end
      end

      ST_SWEEP: begin
        if (last_dwell) begin
          dwell_d = '0;
          if (last_code) begin
            state_d = ST_DONE;
            dout_d  = '0;
          end else begin
            cnt_d  = cnt_q + 1'b1;
            dout_d = onehot(cnt_q + 1'b1);
            vld_d  = 1'b1;
          end
        end else begin
          dwell_d = dwell_q + 8'd1;
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
        dout_d  = '0;
      end

      default: begin
        state_d = ST_IDLE;
        dout_d  = '0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Stage p1: registered state and outputs
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      in_ready_q <= 1'b0;
      cnt_q      <= '0;
      dwell_q    <= '0;
      dout_p1    <= '0;
      vld_p1     <= 1'b0;
    end else begin
      state_q    <= state_d;
      in_ready_q <= (state_d == ST_IDLE);
      cnt_q      <= cnt_d;
      dwell_q    <= dwell_d;
      dout_p1    <= dout_d;
      vld_p1     <= vld_d;
    end
  end

  assign bus.in_ready   = in_ready_q;
  assign bus.dout       = pin_level(dout_p1);
  assign bus.dout_valid = vld_p1;
  assign bus.busy       = (state_q != ST_IDLE);
  assign bus.done       = (state_q == ST_DONE);

endmodule

// File: tb/tb_decoder_seq.sv
module tb_decoder_seq;

`ifdef DEC_ACTIVE_LOW_EN
  localparam int SEL_W = 4;
`else
  localparam int SEL_W = 3;
`endif
  localparam int STEP_CYC  = 2;
  localparam int OUT_W     = 2**SEL_W;
  localparam int SWEEP_CYC = OUT_W * STEP_CYC;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  decoder_seq_if #(.SEL_W(SEL_W)) bus ();

  decoder_seq #(
    .SEL_W    (SEL_W),
    .STEP_CYC (STEP_CYC)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  // Scoreboard of expected active-high codes, one entry per dout_valid strobe.
  logic [OUT_W-1:0] exp_q[$];
  logic [OUT_W-1:0] mon_exp;
  logic [OUT_W-1:0] held;     // value dout must hold while idle
  bit               mon_en = 1'b0;

  // Reference: a code's one-hot value is 2**code.
  function automatic logic [OUT_W-1:0] code_val(input int code);
    logic [OUT_W-1:0] one;
    one = 1;
    return one << code;
  endfunction

  function automatic logic [OUT_W-1:0] pins(input logic [OUT_W-1:0] v);
`ifdef DEC_ACTIVE_LOW_EN
    return ~v;
`else
    return v;
`endif
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: pops and compares on every dout_valid strobe.
  always @(negedge clk) begin
    if (mon_en && rst_n) begin
      if (bus.dout_valid) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_strobe: got dout %0h with dout_valid, expected no strobe", bus.dout);
        end else begin
          mon_exp = exp_q.pop_front();
          check("scoreboard_dout", bus.dout, pins(mon_exp));
        end
      end
      check("dout_at_most_one_hot", 64'($countones(pins(bus.dout)) <= 1), 64'd1);
    end
  end

  task automatic clear_inputs();
    bus.in_valid = 1'b0;
    bus.start    = 1'b0;
    bus.mode     = 1'b0;
    bus.en       = 1'b0;
    bus.sel      = '0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    clear_inputs();
    exp_q.delete();
    held = '0;
    #2;
    check("rst_dout", bus.dout, pins('0));
    check("rst_dout_valid", bus.dout_valid, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.done, 0);
    check("rst_in_ready", bus.in_ready, 0);
    @(negedge clk);
    rst_n  = 1'b1;
    mon_en = 1'b1;
    #1;
    check("in_ready_before_first_edge", bus.in_ready, 0);
    @(negedge clk);
    check("in_ready_after_first_edge", bus.in_ready, 1);
    check("busy_after_reset", bus.busy, 0);
  endtask

  task automatic drive_direct(input int s, input logic e);
    @(negedge clk);
    check("direct_in_ready", bus.in_ready, 1);
    bus.in_valid = 1'b1;
    bus.mode     = 1'b0;
    bus.start    = 1'b0;
    bus.sel      = SEL_W'(s);
    bus.en       = e;
    held = e ? code_val(s) : '0;
    exp_q.push_back(held);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      check("idle_hold_dout", bus.dout, pins(held));
      check("idle_busy", bus.busy, 0);
      check("idle_in_ready", bus.in_ready, 1);
      bus.in_valid = 1'b0;
      bus.start    = 1'b0;
      bus.mode     = 1'($urandom);
      bus.sel      = SEL_W'($urandom);
      bus.en       = 1'($urandom);
    end
  endtask

  // abort_at < 0: full sweep; otherwise assert reset in that sweep cycle.
  task automatic sweep(input bit noise, input int abort_at);
    @(negedge clk);
    check("sweep_start_in_ready", bus.in_ready, 1);
    bus.mode     = 1'b1;
    bus.start    = 1'b1;
    bus.in_valid = 1'($urandom);
    bus.sel      = SEL_W'($urandom);
    bus.en       = 1'($urandom);
    for (int k = 0; k < OUT_W; k++) exp_q.push_back(code_val(k));
    for (int i = 0; i < SWEEP_CYC; i++) begin
      @(negedge clk);
      check("sweep_busy", bus.busy, 1);
      check("sweep_in_ready", bus.in_ready, 0);
      check("sweep_done_low", bus.done, 0);
      check("sweep_dout", bus.dout, pins(code_val(i / STEP_CYC)));
      check("sweep_dout_valid", bus.dout_valid, 64'((i % STEP_CYC) == 0));
      if (i == abort_at) begin
        #1;
        rst_n = 1'b0;
        #1;
        exp_q.delete();
        held = '0;
        check("abort_dout", bus.dout, pins('0));
        check("abort_busy", bus.busy, 0);
        check("abort_done", bus.done, 0);
        check("abort_in_ready", bus.in_ready, 0);
        clear_inputs();
        repeat (2) begin
          @(negedge clk);
          check("abort_no_done", bus.done, 0);
        end
        rst_n = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("abort_recover_in_ready", bus.in_ready, 1);
        return;
      end
      if (noise) begin
        bus.in_valid = 1'b1;
        bus.sel      = SEL_W'(3);
        bus.start    = 1'b1;
        bus.mode     = 1'($urandom);
        bus.en       = 1'($urandom);
      end else begin
        bus.in_valid = 1'b0;
        bus.start    = 1'b0;
      end
    end
    @(negedge clk);
    check("done_pulse", bus.done, 1);
    check("done_busy", bus.busy, 1);
    check("done_dout", bus.dout, pins('0));
    check("done_dout_valid", bus.dout_valid, 0);
    check("done_in_ready", bus.in_ready, 0);
    clear_inputs();
    held = '0;
    @(negedge clk);
    check("post_sweep_done", bus.done, 0);
    check("post_sweep_busy", bus.busy, 0);
    check("post_sweep_in_ready", bus.in_ready, 1);
    check("post_sweep_dout", bus.dout, pins('0));
  endtask

  initial begin
    clear_inputs();
    held = '0;
    do_reset();

    // Every code, back-to-back.
    for (int s = 0; s < OUT_W; s++) drive_direct(s, 1'b1);
    idle(1);

    // Disabled decode yields the zero pattern.
    drive_direct(5, 1'b0);
    idle(3);

    // Clean sweep, then a sweep with in_valid/start noise.
    sweep(1'b0, -1);
    idle(1);
    sweep(1'b1, -1);
    idle(1);

    // Reset while code 3 is presented.
    sweep(1'b0, 3 * STEP_CYC);
    drive_direct(2, 1'b1);
    idle(2);

    // Randomized mix.
    for (int n = 0; n < 80; n++) begin
      int r;
      r = int'($urandom_range(0, 9));
      if (r < 6) begin
        drive_direct(int'($urandom_range(0, OUT_W - 1)), 1'($urandom));
      end else if (r < 8) begin
        idle(int'($urandom_range(1, 3)));
      end else if (r == 8) begin
        idle(1);
        sweep(1'($urandom), -1);
      end else begin
        // Requests that must not be accepted in IDLE.
        @(negedge clk);
        if ($urandom_range(0, 1) == 0) begin
          bus.in_valid = 1'b1;
          bus.mode     = 1'b1;
          bus.start    = 1'b0;
        end else begin
          bus.in_valid = 1'b0;
          bus.mode     = 1'b0;
          bus.start    = 1'b1;
        end
        bus.sel = SEL_W'($urandom);
        bus.en  = 1'($urandom);
        idle(1);
      end
    end
    idle(3);

    check("scoreboard_drained", 64'(exp_q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
